// File: rtl/pfb_seq_pkg.sv
// Shared types and helpers for the polyphase filter bank sequencer.
package pfb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RUN,
    RELOAD
  } state_t;

  localparam int MAX_FFT     = 512;
  localparam int PHASE_W     = 9;
  localparam int FLUSH_CNT_W = 14;
  localparam int SIZE_W      = 10;

  function automatic logic size_legal(
    input logic [SIZE_W-1:0] s,
    input int                min_fft
  );
    return (s != '0)
      && ((s & (s - SIZE_W'(1))) == '0)
      && (int'(s) >= min_fft)
      && (int'(s) <= MAX_FFT);
  endfunction

endpackage

// File: rtl/pfb_seq_tag_dly.sv
// Single-bit delay line aligning the discard tag with the filter output.
module pfb_seq_tag_dly #(
  parameter int DEPTH = 40
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      sr <= '0;
    end else begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pfb_2x_seq.sv
// Sample/phase sequencer for the M/2 polyphase filter bank.
// Optional frame check on s_axis_tlast: define PFB_FRAME_CHK_EN.
module pfb_2x_seq
  import pfb_seq_pkg::*;
#(
  parameter int NUM_TAPS    = 24,
  parameter int PFB_LATENCY = 40,
  parameter int MIN_FFT     = 8
) (
  input  logic               clk,
  input  logic               sync_reset,
  input  logic [9:0]         cfg_fft_size,
  input  logic               cfg_valid,
  output logic               cfg_err,
  input  logic [35:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  input  logic               dn_stall,
  input  logic               reload_req,
  output logic               reload_gnt,
  input  logic               reload_done,
  output logic [9:0]         pfb_fft_size,
  output logic [8:0]         pfb_phase,
  output logic [35:0]        pfb_sig,
  output logic               pfb_valid,
  output logic               out_discard,
  output logic               busy
);

  state_t                   state, state_nxt;
  logic [SIZE_W-1:0]        fft_size, fft_size_nxt;
  logic [SIZE_W-1:0]        pend_size;
  logic                     pend_valid;
  logic [PHASE_W-1:0]       phase, phase_nxt;
  logic [FLUSH_CNT_W-1:0]   flush_cnt, flush_cnt_nxt;
  logic [FLUSH_CNT_W-1:0]   flush_len;
  logic                     issue, flushing, take_pend, frame_err;
  logic                     boundary, phase_last, flush_last, cfg_ok;
  logic                     tag_q;

  assign flush_len  = FLUSH_CNT_W'(NUM_TAPS) * FLUSH_CNT_W'(fft_size);
  assign boundary   = (phase == '0);
  assign phase_last = ({1'b0, phase} == fft_size - SIZE_W'(1));
  assign flush_last = (flush_cnt == flush_len - FLUSH_CNT_W'(1));
  assign cfg_ok     = size_legal(cfg_fft_size, MIN_FFT);

  assign pfb_fft_size = fft_size;
  assign reload_gnt   = (state == RELOAD);

  always_comb begin
    state_nxt     = state;
    fft_size_nxt  = fft_size;
    phase_nxt     = phase;
    flush_cnt_nxt = flush_cnt;
    issue         = 1'b0;
    flushing      = 1'b0;
    take_pend     = 1'b0;
    frame_err     = 1'b0;
    s_axis_tready = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_valid) begin
          take_pend     = 1'b1;
          fft_size_nxt  = pend_size;
          phase_nxt     = '0;
          flush_cnt_nxt = '0;
          state_nxt     = FLUSH;
        end
      end
      FLUSH: begin
        if (boundary && reload_req) begin
          state_nxt = RELOAD;
        end else if (!dn_stall) begin
          issue         = 1'b1;
          flushing      = 1'b1;
          flush_cnt_nxt = flush_cnt + 1'b1;
          // count is a multiple of the size, so this is also a boundary
          if (flush_last) state_nxt = RUN;
        end
      end
      RUN: begin
        if (boundary && reload_req) begin
          state_nxt = RELOAD;
        end else if (boundary && pend_valid) begin
          take_pend     = 1'b1;
          fft_size_nxt  = pend_size;
          flush_cnt_nxt = '0;
          state_nxt     = FLUSH;
        end else begin
          s_axis_tready = !dn_stall;
          issue         = s_axis_tvalid && !dn_stall;
`ifdef PFB_FRAME_CHK_EN
          frame_err = issue && s_axis_tlast && !phase_last;
          if (frame_err) begin
            flush_cnt_nxt = '0;
            state_nxt     = FLUSH;
          end
`endif
        end
      end
      RELOAD: begin
        if (reload_done) begin
          phase_nxt     = '0;
          flush_cnt_nxt = '0;
          state_nxt     = FLUSH;
          if (pend_valid) begin
            take_pend    = 1'b1;
            fft_size_nxt = pend_size;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (issue) begin
      phase_nxt = (phase_last || frame_err) ? '0 : phase + 1'b1;
    end
  end

`ifndef PFB_FRAME_CHK_EN
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state      <= IDLE;
      fft_size   <= '0;
      phase      <= '0;
      flush_cnt  <= '0;
      pend_valid <= 1'b0;
      pend_size  <= '0;
      cfg_err    <= 1'b0;
      pfb_valid  <= 1'b0;
      pfb_phase  <= '0;
      pfb_sig    <= '0;
      tag_q      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state     <= state_nxt;
      fft_size  <= fft_size_nxt;
      phase     <= phase_nxt;
      flush_cnt <= flush_cnt_nxt;
      // a request arriving as the old one is consumed stays pending
      if (take_pend) pend_valid <= 1'b0;
      if (cfg_valid && cfg_ok) begin
        pend_valid <= 1'b1;
        pend_size  <= cfg_fft_size;
      end
      cfg_err   <= (cfg_valid && !cfg_ok) || frame_err;
      pfb_valid <= issue;
      tag_q     <= issue && flushing;
      if (issue) begin
        pfb_phase <= phase;
        pfb_sig   <= flushing ? '0 : s_axis_tdata;
      end
      busy <= (state_nxt != RUN);
    end
  end

  pfb_seq_tag_dly #(
    .DEPTH (PFB_LATENCY)
  ) u_tag_dly (
    .clk        (clk),
    .sync_reset (sync_reset),
    .din        (tag_q),
    .dout       (out_discard)
  );

endmodule
